packer_arbiter: RTL

PACKER_ARBITER -- requirements
Module: packer_arbiter

---
 rtl/packer_arbiter_if.sv | 23 ++
 rtl/packer_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/packer_arbiter_if.sv
// Beat-level bus between NUM_REQ requesters, the arbiter and one data_packer.
// The master modport is the arbiter's view; slave is the requester/packer side.
interface packer_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int IN_WIDTH = 64
);
  logic [NUM_REQ-1:0]          s_req;
  logic [NUM_REQ*IN_WIDTH-1:0] s_data;
  logic [NUM_REQ-1:0]          s_ready;
  logic                        p_write_req;
  logic                        p_write_ready;
  logic [IN_WIDTH-1:0]         p_write_data;

  modport master (
    input  s_req, s_data, p_write_ready,
    output s_ready, p_write_req, p_write_data
  );

  modport slave (
    output s_req, s_data, p_write_ready,
    input  s_ready, p_write_req, p_write_data
  );
endinterface

// File: rtl/packer_arbiter.sv
// Round-robin arbiter that locks one requester onto the packer for a whole
// output word, re-arbitrating on the final beat so words run back to back.
module packer_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int IN_WIDTH  = 64,
  parameter  int OUT_WIDTH = 128,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  packer_arbiter_if.master bus,
  output logic             busy,
  output logic             word_done,
  output logic [ID_W-1:0]  word_owner
);

  localparam int WORD_BEATS = (OUT_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  localparam int BCNT_W     = (WORD_BEATS > 1) ? $clog2(WORD_BEATS) : 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(WORD_BEATS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_gnt;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [ID_W-1:0]     r_last_owner;
  logic                r_word_done;
  logic [ID_W-1:0]     r_word_owner;

  state_t              w_state_nxt;
  logic [ID_W-1:0]     w_gnt_nxt;
  logic [BCNT_W-1:0]   w_bcnt_nxt;
  logic                w_gnt_req;
  logic [IN_WIDTH-1:0] w_gnt_data;
  logic [NUM_REQ-1:0]  w_ready;
  logic                w_beat;
  logic                w_last;
  logic [ID_W-1:0]     w_rr_base;
  logic [ID_W-1:0]     w_rr_cand;
  logic [ID_W-1:0]     w_rr_idx;
  logic                w_rr_found;

  assign w_beat = (r_state == ST_LOCKED) && w_gnt_req && bus.p_write_ready;
  assign w_last = w_beat && (r_bcnt == LAST_BEAT);

  // Grantee mux: request, data and the one-hot accept all follow r_gnt.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_gnt_req  = 1'b0;
    w_gnt_data = '0;
    w_ready    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt == ID_W'(i)) begin
        w_gnt_req  = bus.s_req[i];
        w_gnt_data = bus.s_data[i*IN_WIDTH +: IN_WIDTH];
        w_ready[i] = w_beat;
      end
    end
  end

  // Search starts one past the base, so the base itself is checked last.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_rr_cand  = '0;
    w_rr_base  = (r_state == ST_LOCKED) ? r_gnt : r_last_owner;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_rr_cand = ID_W'((int'(w_rr_base) + i) % NUM_REQ);
      if (!w_rr_found && bus.s_req[w_rr_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_rr_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_bcnt_nxt  = r_bcnt;
    unique case (r_state)
      ST_IDLE: begin
        if (enable && w_rr_found) begin
          w_state_nxt = ST_LOCKED;
          w_gnt_nxt   = w_rr_idx;
          w_bcnt_nxt  = '0;
        end
      end
      ST_LOCKED: begin
        // A stalled grantee simply holds the grant; only a full word releases it.
        if (w_last) begin
          w_bcnt_nxt = '0;
          if (enable && w_rr_found) begin
            w_gnt_nxt = w_rr_idx;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_beat) begin
          w_bcnt_nxt = r_bcnt + BCNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_bcnt       <= '0;
      r_last_owner <= ID_W'(NUM_REQ - 1);
      r_word_done  <= 1'b0;
      r_word_owner <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_word_done <= w_last;
      if (w_last) begin
        r_last_owner <= r_gnt;
        r_word_owner <= r_gnt;
      end
    end
  end

  assign bus.p_write_req  = w_beat;
  assign bus.s_ready      = w_ready;
  assign bus.p_write_data = w_gnt_data;
  assign busy             = (r_state == ST_LOCKED);
  assign word_done        = r_word_done;
  assign word_owner       = r_word_owner;

endmodule
